ysyx_25040101_exec_fsm: RTL and testbench

Multi-cycle sequencer for the single-issue core. It drives the instruction-fetch handshake and steps each instruction through decode/execute and optional memory access. It gates register-file and PC writes and halts the core on ebreak, illegal instruction or bus timeout. It sits between the fetch/LSU bus ports and the decoder/regfile/PC, and replaces the always-on write enables currently derived purely from decode.

---
 rtl/ysyx_25040101_exec_fsm.sv | 179 +++++++++++++++++
 tb/tb_ysyx_25040101_exec_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040101_exec_fsm.sv
// Multi-cycle instruction sequencer: fetch handshake, decode/execute, optional
// data-memory access, gated regfile/PC writes and halt on ebreak/illegal/timeout.
module ysyx_25040101_exec_fsm #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid_o,
   input  logic        ifu_req_ready_i,
   input  logic        ifu_resp_valid_i,
   output logic        ifu_resp_ready_o,
   output logic        ir_wen_o,
   input  logic        is_load_i,
   input  logic        is_store_i,
   input  logic        is_ebreak_i,
   input  logic        is_illegal_i,
   input  logic        rd_wen_dec_i,
   output logic        lsu_req_valid_o,
   input  logic        lsu_req_ready_i,
   input  logic        lsu_resp_valid_i,
   output logic        rd_wen_o,
   output logic        pc_wen_o,
   output logic        halt_o,
   output logic [1:0]  trap_code_o,
   output logic [31:0] cycle_cnt_o,
   output logic [31:0] instret_o
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_IWAIT = 3'd1,
      S_EXEC  = 3'd2,
      S_MREQ  = 3'd3,
      S_MWAIT = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   // The wait counter trips on the cycle whose increment would reach TIMEOUT.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 32'd1);

   state_t      state_r;
   logic [15:0] tmo_cnt_r;
   logic        ld_r;
   logic        rdw_r;
   logic        halt_r;
   logic [1:0]  trap_r;
   logic [31:0] cycle_cnt_r;
   logic [31:0] instret_r;

   logic        bus_wait_s;
   logic        hs_done_s;
   logic        tmo_hit_s;
   logic        exec_mem_s;
   logic        exec_alu_s;
   logic        retire_s;

   // Bus-state classification and timeout detection.
   always_comb begin
      bus_wait_s = 1'b0;
      hs_done_s  = 1'b0;
      case (state_r)
         S_FETCH: begin bus_wait_s = 1'b1; hs_done_s = ifu_req_ready_i;  end
         S_IWAIT: begin bus_wait_s = 1'b1; hs_done_s = ifu_resp_valid_i; end
         S_MREQ:  begin bus_wait_s = 1'b1; hs_done_s = lsu_req_ready_i;  end
         S_MWAIT: begin bus_wait_s = 1'b1; hs_done_s = lsu_resp_valid_i; end
         default: begin bus_wait_s = 1'b0; hs_done_s = 1'b0;             end
      endcase
      tmo_hit_s  = bus_wait_s & ~hs_done_s & (tmo_cnt_r == TMO_LAST);
      exec_mem_s = is_load_i | is_store_i;
      exec_alu_s = ~is_illegal_i & ~is_ebreak_i & ~exec_mem_s;
   end

   // Handshake and write-enable outputs decoded from the current state.
   always_comb begin
      ifu_req_valid_o  = 1'b0;
      ifu_resp_ready_o = 1'b0;
      ir_wen_o         = 1'b0;
      lsu_req_valid_o  = 1'b0;
      rd_wen_o         = 1'b0;
      pc_wen_o         = 1'b0;
      retire_s         = 1'b0;
      case (state_r)
         S_FETCH: ifu_req_valid_o = 1'b1;
         S_IWAIT: begin
            ifu_resp_ready_o = 1'b1;
            ir_wen_o         = ifu_resp_valid_i;
         end
         S_EXEC: begin
            if (exec_alu_s) begin
               pc_wen_o = 1'b1;
               rd_wen_o = rd_wen_dec_i;
               retire_s = 1'b1;
            end else begin
               pc_wen_o = 1'b0;
               rd_wen_o = 1'b0;
               retire_s = ~is_illegal_i & is_ebreak_i;
            end
         end
         S_MREQ: lsu_req_valid_o = 1'b1;
         S_MWAIT: begin
            if (lsu_resp_valid_i) begin
               pc_wen_o = 1'b1;
               rd_wen_o = ld_r & rdw_r;
               retire_s = 1'b1;
            end else begin
               pc_wen_o = 1'b0;
               rd_wen_o = 1'b0;
               retire_s = 1'b0;
            end
         end
         default: begin
            ifu_req_valid_o = 1'b0;
            lsu_req_valid_o = 1'b0;
         end
      endcase
   end

   // Sequencer state, wait counter, trap capture and performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_FETCH;
         tmo_cnt_r   <= 16'd0;
         ld_r        <= 1'b0;
         rdw_r       <= 1'b0;
         halt_r      <= 1'b0;
         trap_r      <= 2'b00;
         cycle_cnt_r <= 32'd0;
         instret_r   <= 32'd0;
      end else begin
         if (state_r != S_HALT) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
         end
         if (retire_s) begin
            instret_r <= instret_r + 32'd1;
         end
         if (tmo_hit_s) begin
            state_r   <= S_HALT;
            halt_r    <= 1'b1;
            trap_r    <= 2'b11;
            tmo_cnt_r <= 16'd0;
         end else if (bus_wait_s && !hs_done_s) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
         end else begin
            tmo_cnt_r <= 16'd0;
            case (state_r)
               S_FETCH: state_r <= S_IWAIT;
               S_IWAIT: state_r <= S_EXEC;
               S_EXEC: begin
                  if (is_illegal_i) begin
                     state_r <= S_HALT;
                     halt_r  <= 1'b1;
                     trap_r  <= 2'b10;
                  end else if (is_ebreak_i) begin
                     state_r <= S_HALT;
                     halt_r  <= 1'b1;
                     trap_r  <= 2'b01;
                  end else if (exec_mem_s) begin
                     ld_r    <= is_load_i;
                     rdw_r   <= rd_wen_dec_i;
                     state_r <= S_MREQ;
                  end else begin
                     state_r <= S_FETCH;
                  end
               end
               S_MREQ:  state_r <= S_MWAIT;
               S_MWAIT: state_r <= S_FETCH;
               S_HALT:  state_r <= S_HALT;
               default: state_r <= S_FETCH;
            endcase
         end
      end
   end

   assign halt_o      = halt_r;
   assign trap_code_o = trap_r;
   assign cycle_cnt_o = cycle_cnt_r;
   assign instret_o   = instret_r;

endmodule

// File: tb/tb_ysyx_25040101_exec_fsm.sv
// Per-cycle vector table for the exec sequencer; expectations flow through a
// scoreboard queue and are compared just before each rising edge.
module tb_ysyx_25040101_exec_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid_o, ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_ready_o, ir_wen_o;
   logic        is_load_i, is_store_i, is_ebreak_i, is_illegal_i, rd_wen_dec_i;
   logic        lsu_req_valid_o, lsu_req_ready_i, lsu_resp_valid_i;
   logic        rd_wen_o, pc_wen_o, halt_o;
   logic [1:0]  trap_code_o;
   logic [31:0] cycle_cnt_o, instret_o;

   ysyx_25040101_exec_fsm #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_ready_i(ifu_req_ready_i),
      .ifu_resp_valid_i(ifu_resp_valid_i), .ifu_resp_ready_o(ifu_resp_ready_o),
      .ir_wen_o(ir_wen_o), .is_load_i(is_load_i), .is_store_i(is_store_i),
      .is_ebreak_i(is_ebreak_i), .is_illegal_i(is_illegal_i), .rd_wen_dec_i(rd_wen_dec_i),
      .lsu_req_valid_o(lsu_req_valid_o), .lsu_req_ready_i(lsu_req_ready_i),
      .lsu_resp_valid_i(lsu_resp_valid_i), .rd_wen_o(rd_wen_o), .pc_wen_o(pc_wen_o),
      .halt_o(halt_o), .trap_code_o(trap_code_o), .cycle_cnt_o(cycle_cnt_o),
      .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   localparam bit [9:0] I_NONE = 10'h000, I_RST = 10'h200, I_IRDY = 10'h100, I_IRSP = 10'h080,
                        I_LD = 10'h040, I_ST = 10'h020, I_EBK = 10'h010, I_ILL = 10'h008,
                        I_RDW = 10'h004, I_LRDY = 10'h002, I_LRSP = 10'h001;
   localparam bit [8:0] O_NONE = 9'h000, O_IFV = 9'h100, O_IRR = 9'h080, O_IRW = 9'h040,
                        O_LQV = 9'h020, O_RDW = 9'h010, O_PCW = 9'h008, O_HLT = 9'h004,
                        O_T01 = 9'h001, O_T10 = 9'h002, O_T11 = 9'h003;

   typedef struct {
      string       name;
      bit [9:0]    stim;
      bit [8:0]    exp;
      bit          chk;
      bit          chk_cnt;
      logic [31:0] cyc;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add(string n, bit [9:0] s, bit [8:0] e);
      vecs.push_back('{n, s, e, 1'b1, 1'b0, 32'd0, 32'd0});
   endfunction

   function automatic void addc(string n, bit [9:0] s, bit [8:0] e, int unsigned c, int unsigned r);
      vecs.push_back('{n, s, e, 1'b1, 1'b1, 32'(c), 32'(r)});
   endfunction

   function automatic void add_rst();
      vecs.push_back('{"rst", I_RST, O_NONE, 1'b0, 1'b0, 32'd0, 32'd0});
   endfunction

   function automatic void alu(string n, bit rdw);
      add({n, "_fetch"}, I_IRDY, O_IFV);
      add({n, "_iwait"}, I_IRSP, O_IRR | O_IRW);
      add({n, "_exec"}, rdw ? I_RDW : I_NONE, rdw ? (O_RDW | O_PCW) : O_PCW);
   endfunction

   function automatic void build();
      // Four zero-wait ALU ops: pc_wen on cycles 3, 6, 9, 12.
      add_rst();
      for (int i = 0; i < 4; i++) alu("A_alu", 1'b1);
      addc("A_end", I_NONE, O_IFV, 12, 4);
      // Load with delayed fetch accept and delayed response: 10 cycles.
      add_rst();
      addc("B_f1", I_NONE, O_IFV, 0, 0);
      add("B_f2", I_NONE, O_IFV);
      add("B_f3", I_IRDY, O_IFV);
      add("B_iw", I_IRSP, O_IRR | O_IRW);
      add("B_ex", I_LD | I_RDW, O_NONE);
      add("B_mq", I_LRDY, O_LQV);
      for (int i = 0; i < 3; i++) add("B_mw", I_NONE, O_NONE);
      add("B_ack", I_LRSP, O_RDW | O_PCW);
      addc("B_end", I_NONE, O_IFV, 10, 1);
      // Store never writes rd; load with rd_wen_dec=0 also does not.
      add_rst();
      add("C_f", I_IRDY, O_IFV);
      add("C_iw", I_IRSP, O_IRR | O_IRW);
      add("C_ex", I_ST | I_RDW, O_NONE);
      add("C_mq1", I_NONE, O_LQV);
      add("C_mq2", I_LRDY, O_LQV);
      add("C_ack", I_LRSP, O_PCW);
      addc("C_f2", I_IRDY, O_IFV, 6, 1);
      add("C_iw2", I_IRSP, O_IRR | O_IRW);
      add("C_ex2", I_LD, O_NONE);
      add("C_mq3", I_LRDY, O_LQV);
      add("C_ack2", I_LRSP, O_PCW);
      addc("C_end", I_NONE, O_IFV, 11, 2);
      // Ebreak after two ALU ops; counters frozen while halted.
      add_rst();
      alu("D_alu", 1'b0);
      alu("D_alu", 1'b0);
      add("D_f", I_IRDY, O_IFV);
      add("D_iw", I_IRSP, O_IRR | O_IRW);
      addc("D_ebk", I_EBK | I_RDW, O_NONE, 8, 2);
      for (int i = 0; i < 20; i++)
         addc("D_halt", I_IRDY | I_IRSP | I_LRDY | I_LRSP | I_RDW, O_HLT | O_T01, 9, 3);
      // Illegal outranks ebreak and load; ebreak outranks store.
      add_rst();
      add("E_f", I_IRDY, O_IFV);
      add("E_iw", I_IRSP, O_IRR | O_IRW);
      add("E_ex", I_ILL | I_EBK | I_LD | I_RDW, O_NONE);
      addc("E_halt", I_NONE, O_HLT | O_T10, 3, 0);
      addc("E_halt", I_IRDY, O_HLT | O_T10, 3, 0);
      add_rst();
      add("E2_f", I_IRDY, O_IFV);
      add("E2_iw", I_IRSP, O_IRR | O_IRW);
      add("E2_ex", I_EBK | I_ST, O_NONE);
      addc("E2_halt", I_NONE, O_HLT | O_T01, 3, 1);
      // IWAIT timeout after exactly 8 waiting cycles.
      add_rst();
      add("F_f", I_IRDY, O_IFV);
      for (int i = 0; i < 8; i++) add("F_iw", I_NONE, O_IRR);
      addc("F_halt", I_NONE, O_HLT | O_T11, 9, 0);
      addc("F_halt", I_IRSP, O_HLT | O_T11, 9, 0);
      // Response on the 8th IWAIT cycle wins over the timeout.
      add_rst();
      add("G_f", I_IRDY, O_IFV);
      for (int i = 0; i < 7; i++) add("G_iw", I_NONE, O_IRR);
      add("G_iw8", I_IRSP, O_IRR | O_IRW);
      add("G_ex", I_RDW, O_RDW | O_PCW);
      addc("G_end", I_NONE, O_IFV, 10, 1);
      // FETCH and MWAIT timeouts.
      add_rst();
      for (int i = 0; i < 8; i++) add("FF_f", I_NONE, O_IFV);
      addc("FF_halt", I_NONE, O_HLT | O_T11, 8, 0);
      add_rst();
      add("FM_f", I_IRDY, O_IFV);
      add("FM_iw", I_IRSP, O_IRR | O_IRW);
      add("FM_ex", I_LD | I_RDW, O_NONE);
      add("FM_mq", I_LRDY, O_LQV);
      for (int i = 0; i < 8; i++) add("FM_mw", I_NONE, O_NONE);
      addc("FM_halt", I_LRSP, O_HLT | O_T11, 12, 0);
      // Reset during MWAIT abandons the load; late response ignored.
      add_rst();
      add("H_f", I_IRDY, O_IFV);
      add("H_iw", I_IRSP, O_IRR | O_IRW);
      add("H_ex", I_LD | I_RDW, O_NONE);
      add("H_mq", I_LRDY, O_LQV);
      add("H_mw", I_NONE, O_NONE);
      add("H_mw_rst", I_RST, O_NONE);
      addc("H_late", I_LRSP, O_IFV, 0, 0);
      alu("H_alu", 1'b1);
      addc("H_end", I_NONE, O_IFV, 4, 1);
   endfunction

   initial begin
      vec_t       cur;
      logic [8:0] got;
      {rst, ifu_req_ready_i, ifu_resp_valid_i, is_load_i, is_store_i, is_ebreak_i,
       is_illegal_i, rd_wen_dec_i, lsu_req_ready_i, lsu_resp_valid_i} = I_RST;
      build();
      foreach (vecs[k]) begin
         @(negedge clk);
         {rst, ifu_req_ready_i, ifu_resp_valid_i, is_load_i, is_store_i, is_ebreak_i,
          is_illegal_i, rd_wen_dec_i, lsu_req_ready_i, lsu_resp_valid_i} = vecs[k].stim;
         exp_q.push_back(vecs[k]);
         #2;
         cur = exp_q.pop_front();
         got = {ifu_req_valid_o, ifu_resp_ready_o, ir_wen_o, lsu_req_valid_o,
                rd_wen_o, pc_wen_o, halt_o, trap_code_o};
         if (cur.chk) begin
            n_cmp++;
            if (got !== cur.exp) begin
               n_bad++;
               $display("FAIL %s[%0d]: outputs got %b want %b", cur.name, k, got, cur.exp);
            end
         end
         if (cur.chk_cnt) begin
            n_cmp++;
            if (cycle_cnt_o !== cur.cyc || instret_o !== cur.ret) begin
               n_bad++;
               $display("FAIL %s[%0d]: cycle/instret got %0d/%0d want %0d/%0d",
                        cur.name, k, cycle_cnt_o, instret_o, cur.cyc, cur.ret);
            end
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
